// File: rtl/csel_pkg.sv
// Shared types and constants for the clocked N-way conditional split.
package csel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold,
    StFree
  } state_e;

  localparam int unsigned CNT_W = 4;

  // Channel-select width; never narrower than one bit.
  function automatic int unsigned selWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/free_pend_latch.sv
// Saturating one-bit free-pending flag for a single downstream channel.
module free_pend_latch #(
  parameter logic InitVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic setPulse,
  input  logic consume,
  output logic pend,
  output logic effFree
);

  logic pendQ;

  // A new pulse coinciding with a consume keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendQ <= InitVal;
    end else begin
      pendQ <= (pendQ & ~consume) | setPulse;
    end
  end

  assign pend    = pendQ;
  assign effFree = pendQ | setPulse;

endmodule

// File: rtl/csel_split_n_sync.sv
// Routes one token per drive pulse to one of N_OUT channels and returns a delayed free upstream.
// Optional macro CSEL_SEL_ERR_EN adds a sticky o_selErr flag for non-one-hot selects.
module csel_split_n_sync
  import csel_pkg::*;
#(
  parameter int unsigned      N_OUT     = 4,
  parameter int unsigned      FREE_DLY  = 2,
  parameter logic [N_OUT-1:0] INIT_FREE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drive,
  input  logic [N_OUT-1:0] i_valid,
  input  logic [N_OUT-1:0] i_freeNext,
  output logic             o_free,
  output logic [N_OUT-1:0] o_driveNext,
  output logic             o_busy
`ifdef CSEL_SEL_ERR_EN
  ,
  output logic             o_selErr
`endif
);

  localparam int unsigned SelW = selWidth(N_OUT);

  state_e           stateQ, stateD;
  logic [SelW-1:0]  selQ, selD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [N_OUT-1:0] driveQ, driveD;
  logic             freeQ, busyQ;
  logic [N_OUT-1:0] freePend, effFree, consume;
  logic [SelW-1:0]  lowIdx;
  logic             accept;

  for (genvar k = 0; k < N_OUT; k++) begin : gen_latch
    free_pend_latch #(
      .InitVal(INIT_FREE[k])
    ) u_latch (
      .clk     (clk),
      .rst     (rst),
      .setPulse(i_freeNext[k]),
      .consume (consume[k]),
      .pend    (freePend[k]),
      .effFree (effFree[k])
    );
  end

  always_comb begin
    lowIdx = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (i_valid[i]) lowIdx = SelW'(i);
    end
  end

`ifdef CSEL_SEL_ERR_EN
  logic validOneHot;
  logic selErrQ;

  assign validOneHot = (i_valid != '0) && ((i_valid & (i_valid - N_OUT'(1))) == '0);
  assign accept      = validOneHot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      selErrQ <= 1'b0;
    end else if (stateQ == StIdle && i_drive && !validOneHot) begin
      selErrQ <= 1'b1;
    end
  end

  assign o_selErr = selErrQ;
`else
  assign accept = |i_valid;
`endif

  always_comb begin
    stateD  = stateQ;
    selD    = selQ;
    cntD    = cntQ;
    driveD  = '0;
    consume = '0;
    case (stateQ)
      StIdle: begin
        if (i_drive) begin
          if (accept) begin
            selD           = lowIdx;
            driveD[lowIdx] = 1'b1;
            stateD         = StWait;
          end else if (FREE_DLY == 0) begin
            // Dropped token: release upstream without waiting on a channel.
            stateD = StFree;
          end else begin
            cntD   = CNT_W'(FREE_DLY);
            stateD = StHold;
          end
        end
      end
      StWait: begin
        if (effFree[selQ]) begin
          consume[selQ] = 1'b1;
          if (FREE_DLY == 0) begin
            stateD = StFree;
          end else begin
            cntD   = CNT_W'(FREE_DLY);
            stateD = StHold;
          end
        end
      end
      StHold: begin
        if (cntQ == CNT_W'(1)) begin
          stateD = StFree;
        end else begin
          cntD = cntQ - CNT_W'(1);
        end
      end
      StFree: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      selQ   <= '0;
      cntQ   <= '0;
      driveQ <= '0;
      freeQ  <= 1'b0;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      selQ   <= selD;
      cntQ   <= cntD;
      driveQ <= driveD;
      freeQ  <= (stateD == StFree);
      busyQ  <= (stateD != StIdle);
    end
  end

  assign o_driveNext = driveQ;
  assign o_free      = freeQ;
  assign o_busy      = busyQ;

endmodule

// File: tb/tb_csel_split_n_sync.sv
// Randomised and directed bench for csel_split_n_sync, two instances against a timing reference model.
module tb_csel_split_n_sync;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         drive;
  logic [N-1:0] valid, freeNext;
  logic [N-1:0] drv0, drv1;
  logic         free0, free1, busy0, busy1;
`ifdef CSEL_SEL_ERR_EN
  logic         selErr0, selErr1;
`endif

  always #5 clk = ~clk;

  csel_split_n_sync #(.N_OUT(4), .FREE_DLY(2), .INIT_FREE(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .i_drive(drive), .i_valid(valid), .i_freeNext(freeNext),
    .o_free(free0), .o_driveNext(drv0), .o_busy(busy0)
`ifdef CSEL_SEL_ERR_EN
    , .o_selErr(selErr0)
`endif
  );

  csel_split_n_sync #(.N_OUT(4), .FREE_DLY(0), .INIT_FREE(4'b1111)) dut1 (
    .clk(clk), .rst(rst), .i_drive(drive), .i_valid(valid), .i_freeNext(freeNext),
    .o_free(free1), .o_driveNext(drv1), .o_busy(busy1)
`ifdef CSEL_SEL_ERR_EN
    , .o_selErr(selErr1)
`endif
  );

  int nChecks = 0;
  int nFail   = 0;
  int edgeN   = 0;

  // Reference model: per instance, a token either waits on a channel or has a known release edge.
  int unsigned  dly   [2] = '{2, 0};
  logic [N-1:0] initF [2] = '{4'b0000, 4'b1111};
  logic [N-1:0] mPend [2];
  logic         mBusy [2];
  logic         mWait [2];
  logic         mSelErr [2];
  int           mSel  [2];
  int           mFreeEdge [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edgeN);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mPend[i]     = initF[i];
      mBusy[i]     = 1'b0;
      mWait[i]     = 1'b0;
      mSelErr[i]   = 1'b0;
      mSel[i]      = 0;
      mFreeEdge[i] = -10;
    end
  endtask

  task automatic model_step(input int i, output logic [N-1:0] eDrv, output logic eFree,
                            output logic eBusy);
    logic [N-1:0] eff;
    logic [N-1:0] nxt;
    int low;
    int ones;
    logic acc;
    eff  = mPend[i] | freeNext;
    nxt  = eff;
    eDrv = '0;
    low  = 0;
    ones = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[k]) begin
        low = k;
        ones++;
      end
    end
`ifdef CSEL_SEL_ERR_EN
    acc = (ones == 1);
`else
    acc = (ones != 0);
`endif
    if (!mBusy[i]) begin
      if (drive) begin
        mBusy[i] = 1'b1;
        if (!(ones == 1)) mSelErr[i] = 1'b1;
        if (acc) begin
          mSel[i]   = low;
          mWait[i]  = 1'b1;
          eDrv[low] = 1'b1;
        end else begin
          mFreeEdge[i] = edgeN + int'(dly[i]);
        end
      end
    end else if (mWait[i]) begin
      if (eff[mSel[i]]) begin
        nxt[mSel[i]] = freeNext[mSel[i]];
        mWait[i]     = 1'b0;
        mFreeEdge[i] = edgeN + int'(dly[i]);
      end
    end else if (edgeN == mFreeEdge[i] + 1) begin
      mBusy[i] = 1'b0;
    end
    mPend[i] = nxt;
    eFree = mBusy[i] && !mWait[i] && (edgeN == mFreeEdge[i]);
    eBusy = mBusy[i];
  endtask

  task automatic do_cycle(input logic d, input logic [N-1:0] v, input logic [N-1:0] f);
    logic [N-1:0] eD0, eD1;
    logic eF0, eF1, eB0, eB1;
    @(negedge clk);
    drive    = d;
    valid    = v;
    freeNext = f;
    @(posedge clk);
    model_step(0, eD0, eF0, eB0);
    model_step(1, eD1, eF1, eB1);
    #1;
    check_eq("drv0", 32'(drv0), 32'(eD0));
    check_eq("free0", 32'(free0), 32'(eF0));
    check_eq("busy0", 32'(busy0), 32'(eB0));
    check_eq("pend0", 32'(dut0.freePend), 32'(mPend[0]));
    check_eq("drv1", 32'(drv1), 32'(eD1));
    check_eq("free1", 32'(free1), 32'(eF1));
    check_eq("busy1", 32'(busy1), 32'(eB1));
    check_eq("pend1", 32'(dut1.freePend), 32'(mPend[1]));
`ifdef CSEL_SEL_ERR_EN
    check_eq("selErr0", 32'(selErr0), 32'(mSelErr[0]));
    check_eq("selErr1", 32'(selErr1), 32'(mSelErr[1]));
`endif
    edgeN++;
  endtask

  initial begin
    logic         rd;
    logic [N-1:0] rv, rf;
    int           freeRel;

    rst      = 1'b0;
    drive    = 1'b0;
    valid    = '0;
    freeNext = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy0", 32'(busy0), 32'd0);
    check_eq("reset_free0", 32'(free0), 32'd0);
    check_eq("reset_drv0", 32'(drv0), 32'd0);
    check_eq("reset_pend0", 32'(dut0.freePend), 32'h0);
    check_eq("reset_pend1", 32'(dut1.freePend), 32'hF);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Basic route: select channel 2, channel free at relative edge 5.
    freeRel = -1;
    for (int r = 0; r < 10; r++) begin
      do_cycle((r == 0), (r == 0) ? 4'b0100 : 4'b0000, (r == 5) ? 4'b0100 : 4'b0000);
      if (r == 0) check_eq("route_drv_cycle1", 32'(drv0), 32'h4);
      if (free0) freeRel = r;
    end
    check_eq("route_free_cycle8", 32'(freeRel), 32'd7);
    check_eq("route_idle_cycle9", 32'(busy0), 32'd0);

    // Drop, multi-hot select and drives while busy.
    do_cycle(1'b1, 4'b0000, 4'b0000);
    repeat (4) do_cycle(1'b0, 4'b0000, 4'b0000);
    do_cycle(1'b1, 4'b0110, 4'b0000);
    do_cycle(1'b1, 4'b0001, 4'b0000);
    do_cycle(1'b1, 4'b1000, 4'b0000);
    repeat (2) do_cycle(1'b0, 4'b0000, 4'b0010);
    repeat (4) do_cycle(1'b0, 4'b0000, 4'b0000);

    for (int c = 0; c < 600; c++) begin
      rd = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       rv = '0;
        1:       rv = 4'($urandom);
        default: rv = 4'b0001 << $urandom_range(0, 3);
      endcase
      rf = 4'($urandom) & 4'($urandom) & 4'($urandom);
      do_cycle(rd, rv, rf);
    end

    // Flush outstanding tokens, then reset in the middle of the hold delay.
    repeat (3) do_cycle(1'b0, 4'b0000, 4'b1111);
    repeat (4) do_cycle(1'b0, 4'b0000, 4'b0000);
    do_cycle(1'b1, 4'b0001, 4'b0000);
    do_cycle(1'b0, 4'b0000, 4'b0000);
    check_eq("hold_busy0", 32'(busy0), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_busy0", 32'(busy0), 32'd0);
    check_eq("arst_free0", 32'(free0), 32'd0);
    check_eq("arst_free1", 32'(free1), 32'd0);
    check_eq("arst_drv0", 32'(drv0), 32'd0);
    check_eq("arst_pend0", 32'(dut0.freePend), 32'h0);
    check_eq("arst_pend1", 32'(dut1.freePend), 32'hF);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) do_cycle(1'b0, 4'b0000, 4'b0000);
    do_cycle(1'b1, 4'b0010, 4'b0000);
    repeat (3) do_cycle(1'b0, 4'b0000, 4'b0010);
    repeat (4) do_cycle(1'b0, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/csel_split_n_sync.md
Name: csel_split_n_sync

Overview:
- Clocked, parametrised successor to the 2-way conditional split in the control fabric.
- Accepts one token per `i_drive` pulse and forwards it to exactly one of N_OUT downstream channels, chosen by the one-hot `i_valid` vector.
- Returns `o_free` upstream once the selected downstream has signalled free, plus a programmable hold delay.
- Sits between a token source and N_OUT memory or compute consumers in the fpgaCtrl control path; data travels separately.

Parameters:
- N_OUT, 4, number of downstream channels (2..16).
- FREE_DLY, 2, extra cycles between accepted downstream free and `o_free` (0..15).
- INIT_FREE, {N_OUT{1'b0}}, reset value of the per-channel free-pending flags (1 = downstream starts free).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_drive  in  1  one-cycle token pulse from upstream.
- i_valid  in  N_OUT  one-hot channel select, qualified by `i_drive`.
- i_freeNext  in  N_OUT  one-cycle free pulse per downstream channel.
- o_free  out  1  one-cycle free pulse to upstream.
- o_driveNext  out  N_OUT  one-cycle drive pulse per downstream channel.
- o_busy  out  1  high whenever a token is outstanding (state != IDLE).

Behaviour:
- Reset (`rst`=0, async):
  - state=IDLE; `o_free`=0, `o_driveNext`=0, `o_busy`=0; counter=0.
  - `free_pend`=INIT_FREE.
  - Any in-flight token is discarded.
- Free tracking:
  - `i_freeNext[k]` sets `free_pend[k]` (saturating 1 bit).
  - A second pulse while already set is dropped.
  - `eff_free[k]` = `free_pend[k]` OR `i_freeNext[k]`.
  - If a consume and a new pulse on the same channel coincide, `free_pend[k]` stays 1.
- States: IDLE, WAIT, HOLD, FREE.
- IDLE:
  - `i_drive`=1 with `i_valid` bit k set → latch sel=k; `o_driveNext[k]` high for the next cycle only (1-cycle latency); go to WAIT.
  - `i_drive`=1 with `i_valid`=0 → token is dropped; no `o_driveNext`; go straight to the free path (HOLD/FREE as below) without waiting on a channel.
- WAIT:
  - If `eff_free[sel]`=1 → clear `free_pend[sel]`.
  - If FREE_DLY=0 → go to FREE; else load counter=FREE_DLY and go to HOLD.
  - Free pulses on other channels are only latched.
- HOLD: counter decrements each cycle; at counter==1 → go to FREE.
- FREE: `o_free`=1 for exactly this cycle; go to IDLE.
- Timing: free sampled at edge e → `o_free` high in the cycle after edge e+FREE_DLY.
- `i_drive` outside IDLE is a protocol violation: ignored, no state change. Upstream may re-drive in the cycle after the `o_free` pulse.
- Multi-hot `i_valid`: lowest set index wins (without the optional feature).
- `o_driveNext` and `o_free` are registered and glitch-free; `o_busy` is a registered decode of state.

Optional Feature:
- Macro: CSEL_SEL_ERR_EN.
- Defined:
  - Adds output port `o_selErr` (1 bit): sticky, set when `i_drive`=1 in IDLE with `i_valid` not one-hot (zero or multi-hot), cleared only by reset.
  - A multi-hot token is dropped like `i_valid`=0: no drive, `o_free` still returned.
- Undefined: no port; lowest-index priority applies; `i_valid`=0 drops silently.

Decomposition:
- Package csel_pkg holds:
  - state enum (IDLE, WAIT, HOLD, FREE);
  - `SEL_W` = clog2(N_OUT) helper function;
  - `CNT_W` = 4 constant.
- Natural sub-module free_pend_latch: one instance per channel holding the saturating flag, set/consume logic and the reset value from INIT_FREE.

Test Plan (N_OUT=4, FREE_DLY=2, INIT_FREE=0 unless stated):
- Basic route:
  - Stimulus: `i_drive` with `i_valid`=0100 at edge 0; `i_freeNext[2]` pulse at edge 5.
  - Response: `o_driveNext`=0100 in cycle 1 only; `o_busy`=1 from cycle 1; `o_free` high in cycle 8 only; `o_busy`=0 in cycle 9.
- Pre-latched free:
  - Stimulus: INIT_FREE=1111, FREE_DLY=0; drive `i_valid`=0001 at edge 0.
  - Response: `o_driveNext[0]` in cycle 1; `o_free` in cycle 2; `free_pend[0]` cleared, others stay 1.
- Wrong-channel free:
  - Stimulus: drive sel=1; `i_freeNext[3]` at edge 3, `i_freeNext[1]` at edge 6.
  - Response: `o_free` only in cycle 9; `free_pend[3]` still 1 afterwards.
- Simultaneous consume and new free:
  - Stimulus: `i_freeNext[0]` at edges 2 and 4, with sel=0 waiting at edge 4.
  - Response: token released; `free_pend[0]`=1 after edge 4.
- Drop and violation:
  - Stimulus: drive with `i_valid`=0000 (response: no `o_driveNext`, `o_free` 3 cycles later); then drive with `i_valid`=0110 under CSEL_SEL_ERR_EN.
  - Response: `o_selErr`=1 sticky, no `o_driveNext`. Without the macro, `o_driveNext`=0010. `i_drive` pulses while `o_busy`=1 cause no change.
- Mid-operation reset:
  - Stimulus: assert `rst`=0 asynchronously in HOLD.
  - Response: outputs go to 0 immediately with no `o_free` pulse; after release, IDLE and `free_pend`=INIT_FREE.
